wb_stage_ex: RTL and testbench

Parametrised write-back stage for the five-stage pipeline, successor to the fixed 32-bit, always-write WB stage. It accepts retiring instructions from MEM over the allowin/valid handshake and drives the register-file write bus with per-byte enables. It also handles precise exceptions and ERET: it suppresses the write, flushes the pipeline, and updates EPC, cause and EXL state. It keeps a retired-instruction counter and drives the trace debug port.

---
 rtl/wb_stage_ex.sv | 175 +++++++++++++++++
 tb/tb_wb_stage_ex.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_ex.sv
// Write-back stage: retires instructions from MEM and drives the register-file
// write bus with per-byte enables. It also owns the precise-exception and ERET
// machinery (flush, EPC/cause/EXL state), the retired-instruction counter and
// the trace debug port.
module wb_stage_ex #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 5,
  parameter int              PC_W     = 32,
  parameter int              WE_W     = DATA_W / 8,
  parameter logic [PC_W-1:0] EX_ENTRY = 32'hbfc00380,
  parameter int              CNT_W    = 32
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  // MEM -> WB handshake
  output logic                                   ws_allowin,
  input  logic                                   ms_to_ws_valid,
  input  logic [7+WE_W+ADDR_W+DATA_W+PC_W-1:0]   ms_to_ws_bus,
  // register-file write bus {rf_we, rf_waddr, rf_wdata}
  output logic [WE_W+ADDR_W+DATA_W-1:0]          ws_to_rf_bus,
  // pipeline redirect
  output logic                                   ws_flush,
  output logic [PC_W-1:0]                        ws_flush_pc,
  // CP0 state
  output logic [PC_W-1:0]                        cp0_epc,
  output logic [4:0]                             cp0_excode,
  output logic                                   cp0_exl,
  // statistics
  output logic [CNT_W-1:0]                       retire_cnt,
  // trace debug port
  output logic [PC_W-1:0]                        debug_wb_pc,
  output logic [WE_W-1:0]                        debug_wb_rf_wen,
  output logic [ADDR_W-1:0]                      debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                      debug_wb_rf_wdata
);

  // Field offsets inside the MEM->WB bus, LSB upwards.
  localparam int OFF_PC   = 0;
  localparam int OFF_RES  = OFF_PC + PC_W;
  localparam int OFF_DEST = OFF_RES + DATA_W;
  localparam int OFF_WE   = OFF_DEST + ADDR_W;
  localparam int OFF_EXC  = OFF_WE + WE_W;
  localparam int OFF_EX   = OFF_EXC + 5;
  localparam int OFF_ERET = OFF_EX + 1;
  localparam int BUS_W    = OFF_ERET + 1;

  // Pipeline state
  logic             ws_valid_q, ws_valid_d;
  logic [BUS_W-1:0] bus_q, bus_d;

  // CP0 state and counter
  logic [PC_W-1:0]  epc_q, epc_d;
  logic [4:0]       excode_q, excode_d;
  logic             exl_q, exl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Decoded fields of the instruction currently held in WB
  logic [PC_W-1:0]   f_pc;
  logic [DATA_W-1:0] f_result;
  logic [ADDR_W-1:0] f_dest;
  logic [WE_W-1:0]   f_byte_we;
  logic [4:0]        f_excode;
  logic              f_ex;
  logic              f_eret;

  // Control
  logic              ws_ready_go;
  logic              ex_fire;
  logic              eret_fire;
  logic              commit;
  logic              flush;
  logic [WE_W-1:0]   rf_we;

  assign f_pc      = bus_q[OFF_PC   +: PC_W];
  assign f_result  = bus_q[OFF_RES  +: DATA_W];
  assign f_dest    = bus_q[OFF_DEST +: ADDR_W];
  assign f_byte_we = bus_q[OFF_WE   +: WE_W];
  assign f_excode  = bus_q[OFF_EXC  +: 5];
  assign f_ex      = bus_q[OFF_EX];
  assign f_eret    = bus_q[OFF_ERET];

  // WB never stalls; allowin depends on the valid flag alone, never on MEM.
  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid_q || ws_ready_go;

  // An exception takes priority over ERET when both flags are set.
  assign ex_fire   = ws_valid_q && f_ex;
  assign eret_fire = ws_valid_q && f_eret && !f_ex;
  assign flush     = ex_fire || eret_fire;
  assign commit    = ws_valid_q && !f_ex && !f_eret;

  // Byte lanes are gated individually; an excepting or empty slot writes nothing.
  assign rf_we = f_byte_we & {WE_W{commit}};

  assign ws_to_rf_bus = {rf_we, f_dest, f_result};

  // ERET returns to the EPC value held before this edge.
  assign ws_flush    = flush;
  assign ws_flush_pc = ex_fire ? EX_ENTRY : epc_q;

  assign cp0_epc    = epc_q;
  assign cp0_excode = excode_q;
  assign cp0_exl    = exl_q;
  assign retire_cnt = cnt_q;

  assign debug_wb_pc       = f_pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = f_dest;
  assign debug_wb_rf_wdata = f_result;

  // Next-state for the handshake: a flush kills WB, dropping whatever MEM offers.
  always_comb begin
    ws_valid_d = ws_valid_q;
    bus_d      = bus_q;
    if (flush) begin
      ws_valid_d = 1'b0;
    end else if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid;
    end
    if (ms_to_ws_valid && ws_allowin) begin
      bus_d = ms_to_ws_bus;
    end
  end

  // Next-state for CP0: nested exceptions keep the original EPC but update the cause.
  always_comb begin
    epc_d    = epc_q;
    excode_d = excode_q;
    exl_d    = exl_q;
    if (ex_fire) begin
      excode_d = f_excode;
      exl_d    = 1'b1;
      if (!exl_q) begin
        epc_d = f_pc;
      end
    end else if (eret_fire) begin
      exl_d = 1'b0;
    end
  end

  // Next-state for the retire counter; wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (commit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline registers; reset discards any in-flight instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      bus_q      <= bus_d;
    end
  end

  // CP0 and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc_q    <= '0;
      excode_q <= '0;
      exl_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      epc_q    <= epc_d;
      excode_q <= excode_d;
      exl_q    <= exl_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_stage_ex.sv
// Directed testbench for wb_stage_ex. A second instance with a 4-bit counter
// shares all inputs with the default instance to exercise counter wrap.
module tb_wb_stage_ex;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W   = 32;
  localparam int WE_W   = 4;
  localparam int BUS_W  = 7 + WE_W + ADDR_W + DATA_W + PC_W;
  localparam int RF_W   = WE_W + ADDR_W + DATA_W;

  logic              clk;
  logic              resetn;
  logic              ms_to_ws_valid;
  logic [BUS_W-1:0]  ms_to_ws_bus;

  logic              ws_allowin;
  logic [RF_W-1:0]   ws_to_rf_bus;
  logic              ws_flush;
  logic [PC_W-1:0]   ws_flush_pc;
  logic [PC_W-1:0]   cp0_epc;
  logic [4:0]        cp0_excode;
  logic              cp0_exl;
  logic [31:0]       retire_cnt;
  logic [PC_W-1:0]   debug_wb_pc;
  logic [WE_W-1:0]   debug_wb_rf_wen;
  logic [ADDR_W-1:0] debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;

  logic              s_allowin;
  logic [RF_W-1:0]   s_rf_bus;
  logic              s_flush;
  logic [PC_W-1:0]   s_flush_pc;
  logic [PC_W-1:0]   s_epc;
  logic [4:0]        s_excode;
  logic              s_exl;
  logic [3:0]        s_cnt;
  logic [PC_W-1:0]   s_dbg_pc;
  logic [WE_W-1:0]   s_dbg_wen;
  logic [ADDR_W-1:0] s_dbg_wnum;
  logic [DATA_W-1:0] s_dbg_wdata;

  int n_chk  = 0;
  int n_pass = 0;

  wb_stage_ex dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .ws_flush          (ws_flush),
    .ws_flush_pc       (ws_flush_pc),
    .cp0_epc           (cp0_epc),
    .cp0_excode        (cp0_excode),
    .cp0_exl           (cp0_exl),
    .retire_cnt        (retire_cnt),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  wb_stage_ex #(.CNT_W(4)) dut_small (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (s_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_to_rf_bus      (s_rf_bus),
    .ws_flush          (s_flush),
    .ws_flush_pc       (s_flush_pc),
    .cp0_epc           (s_epc),
    .cp0_excode        (s_excode),
    .cp0_exl           (s_exl),
    .retire_cnt        (s_cnt),
    .debug_wb_pc       (s_dbg_pc),
    .debug_wb_rf_wen   (s_dbg_wen),
    .debug_wb_rf_wnum  (s_dbg_wnum),
    .debug_wb_rf_wdata (s_dbg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [BUS_W-1:0] pack(input logic eret, input logic ex,
                                            input logic [4:0] excode, input logic [3:0] we,
                                            input logic [4:0] dest, input logic [31:0] res,
                                            input logic [31:0] pc);
    return {eret, ex, excode, we, dest, res, pc};
  endfunction

  task automatic drive(input logic v, input logic [BUS_W-1:0] b);
    @(negedge clk);
    ms_to_ws_valid = v;
    ms_to_ws_bus   = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rf_we_of(input logic [RF_W-1:0] b);
    return b[DATA_W+ADDR_W +: WE_W];
  endfunction

  function automatic logic [4:0] rf_wa_of(input logic [RF_W-1:0] b);
    return b[DATA_W +: ADDR_W];
  endfunction

  function automatic logic [31:0] rf_wd_of(input logic [RF_W-1:0] b);
    return b[DATA_W-1:0];
  endfunction

  initial begin
    resetn         = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_allowin", ws_allowin, 1);
    check("rst_rfbus",   ws_to_rf_bus, 0);
    check("rst_flush",   ws_flush, 0);
    check("rst_epc",     cp0_epc, 0);
    check("rst_exl",     cp0_exl, 0);
    check("rst_cnt",     retire_cnt, 0);
    check("rst_dbgpc",   debug_wb_pc, 0);

    drive(1'b0, '0);
    resetn = 1'b1;

    // back-to-back commits
    drive(1'b1, pack(0, 0, 5'h00, 4'hF, 5'd3, 32'h12345678, 32'hbfc00000));
    step();
    check("i1_we",     rf_we_of(ws_to_rf_bus), 4'hF);
    check("i1_waddr",  rf_wa_of(ws_to_rf_bus), 3);
    check("i1_wdata",  rf_wd_of(ws_to_rf_bus), 32'h12345678);
    check("i1_dbgpc",  debug_wb_pc, 32'hbfc00000);
    check("i1_dbgwen", debug_wb_rf_wen, 4'hF);
    check("i1_allow",  ws_allowin, 1);
    check("i1_cnt",    retire_cnt, 0);
    drive(1'b1, pack(0, 0, 5'h00, 4'hF, 5'd4, 32'h0badf00d, 32'hbfc00004));
    step();
    check("i2_we",    rf_we_of(ws_to_rf_bus), 4'hF);
    check("i2_waddr", rf_wa_of(ws_to_rf_bus), 4);
    check("i2_dbgwn", debug_wb_rf_wnum, 4);
    check("i2_cnt",   retire_cnt, 1);
    check("i2_allow", ws_allowin, 1);

    // partial write
    drive(1'b1, pack(0, 0, 5'h00, 4'h3, 5'd7, 32'hAABBCCDD, 32'hbfc00008));
    step();
    check("i3_we",    rf_we_of(ws_to_rf_bus), 4'h3);
    check("i3_wdata", rf_wd_of(ws_to_rf_bus), 32'hAABBCCDD);
    check("i3_dbgwd", debug_wb_rf_wdata, 32'hAABBCCDD);
    check("i3_cnt",   retire_cnt, 2);

    // idle bubble
    drive(1'b0, '0);
    step();
    check("bub_we",   rf_we_of(ws_to_rf_bus), 0);
    check("bub_dbgw", debug_wb_rf_wen, 0);
    check("bub_cnt",  retire_cnt, 3);
    check("bub_scnt", s_cnt, 3);

    // exception, MEM valid in the flush cycle
    drive(1'b1, pack(0, 1, 5'h0C, 4'hF, 5'd8, 32'h11111111, 32'hbfc00100));
    step();
    check("ex_we",    rf_we_of(ws_to_rf_bus), 0);
    check("ex_flush", ws_flush, 1);
    check("ex_fpc",   ws_flush_pc, 32'hbfc00380);
    drive(1'b1, pack(0, 0, 5'h00, 4'hF, 5'd9, 32'h22222222, 32'hbfc00104));
    #1;
    check("ex_allow", ws_allowin, 1);
    step();
    check("ex_epc",    cp0_epc, 32'hbfc00100);
    check("ex_code",   cp0_excode, 5'h0C);
    check("ex_exl",    cp0_exl, 1);
    check("ex_drop",   rf_we_of(ws_to_rf_bus), 0);
    check("ex_flush0", ws_flush, 0);
    check("ex_cnt",    retire_cnt, 3);
    drive(1'b0, '0);

    // nested exception
    drive(1'b1, pack(0, 1, 5'h08, 4'hF, 5'd1, 32'h0, 32'hbfc00200));
    step();
    check("nex_flush", ws_flush, 1);
    check("nex_fpc",   ws_flush_pc, 32'hbfc00380);
    drive(1'b0, '0);
    step();
    check("nex_epc",  cp0_epc, 32'hbfc00100);
    check("nex_code", cp0_excode, 5'h08);
    check("nex_exl",  cp0_exl, 1);

    // ERET
    drive(1'b1, pack(1, 0, 5'h00, 4'hF, 5'd5, 32'h0, 32'hbfc00400));
    step();
    check("eret_flush", ws_flush, 1);
    check("eret_fpc",   ws_flush_pc, 32'hbfc00100);
    check("eret_we",    rf_we_of(ws_to_rf_bus), 0);
    drive(1'b0, '0);
    step();
    check("eret_exl", cp0_exl, 0);
    check("eret_epc", cp0_epc, 32'hbfc00100);
    check("eret_cnt", retire_cnt, 3);

    // ex and eret together: exception wins
    drive(1'b1, pack(1, 1, 5'h04, 4'hF, 5'd6, 32'h0, 32'hbfc00300));
    step();
    check("both_fpc", ws_flush_pc, 32'hbfc00380);
    drive(1'b0, '0);
    step();
    check("both_exl",  cp0_exl, 1);
    check("both_epc",  cp0_epc, 32'hbfc00300);
    check("both_code", cp0_excode, 5'h04);

    // asynchronous reset mid-cycle with a valid instruction and exl=1
    drive(1'b1, pack(0, 0, 5'h00, 4'hF, 5'd10, 32'h55, 32'hbfc00500));
    step();
    check("pre_we",  rf_we_of(ws_to_rf_bus), 4'hF);
    check("pre_exl", cp0_exl, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_rfbus", ws_to_rf_bus, 0);
    check("arst_exl",   cp0_exl, 0);
    check("arst_epc",   cp0_epc, 0);
    check("arst_code",  cp0_excode, 0);
    check("arst_cnt",   retire_cnt, 0);
    check("arst_scnt",  s_cnt, 0);
    check("arst_dbgpc", debug_wb_pc, 0);
    check("arst_allow", ws_allowin, 1);
    check("arst_flush", ws_flush, 0);
    drive(1'b0, '0);
    resetn = 1'b1;

    // 17 commits (half with byte_we=0) to wrap the 4-bit counter
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, pack(0, 0, 5'h00, (k % 2 == 0) ? 4'hF : 4'h0, 5'(k), 32'(k), 32'hbfc01000 + 32'(4*k)));
    end
    drive(1'b0, '0);
    step();
    check("wrap_cnt",  retire_cnt, 17);
    check("wrap_scnt", s_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
